dram_cmd_issuer: RTL and testbench

DRAM_CMD_ISSUER -- requirements
Module: dram_cmd_issuer

---
 rtl/dram_cmd_issuer.sv | 221 ++++++++++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_issuer.sv
// dram_cmd_issuer: single-entry DRAM command issuer with per-bank timing.
// A scheduler command is latched into a one-entry hold register. It issues
// once its bank timer has expired and, for READ/WRITE, the shared burst
// timer has expired. On issue, all dram_* outputs are registered and
// dram_valid_out pulses for one cycle.
// Optional open-row protocol checking is compiled in by defining the macro
// DRAM_CMD_ISSUER_PROTOCOL_CHECK_EN. Without it, err_out is tied to 0.
module dram_cmd_issuer #(
  parameter int BANK_GROUPS        = 8,
  parameter int BANKS_PER_GROUP    = 8,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 4,
  localparam int BGW = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1,
  localparam int BKW = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [2:0]          cmd_in,
  input  logic                valid_in,
  input  logic [BGW-1:0]      bank_group_in,
  input  logic [BKW-1:0]      bank_in,
  input  logic [ROW_BITS-1:0] row_in,
  input  logic [COL_BITS-1:0] col_in,
  input  logic [63:0]         val_in,
  output logic                cmd_ready,
  output logic [2:0]          dram_cmd_out,
  output logic                dram_valid_out,
  output logic [BGW-1:0]      dram_bg_out,
  output logic [BKW-1:0]      dram_bank_out,
  output logic [ROW_BITS-1:0] dram_row_out,
  output logic [COL_BITS-1:0] dram_col_out,
  output logic [63:0]         dram_wdata_out,
  output logic                err_out
);

  localparam int NB   = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMAX = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                        ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BURST_CYCLES + 1);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_ACT   = 3'b001;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  localparam logic [TW-1:0] ACT_LOAD   = TW'(ACTIVATION_LATENCY - 1);
  localparam logic [TW-1:0] PRE_LOAD   = TW'(PRECHARGE_LATENCY - 1);
  localparam logic [BW-1:0] BURST_LOAD = BW'(BURST_CYCLES - 1);

  logic                r_hold_valid;
  logic [2:0]          r_hold_cmd;
  logic [BGW-1:0]      r_hold_bg;
  logic [BKW-1:0]      r_hold_bank;
  logic [ROW_BITS-1:0] r_hold_row;
  logic [COL_BITS-1:0] r_hold_col;
  logic [63:0]         r_hold_wdata;

  logic [TW-1:0]       r_bank_timer [NB];
  logic [BW-1:0]       r_burst_timer;

  logic                w_accept;
  logic                w_cmd_legal;
  logic                w_is_rw;
  logic                w_issue;
  logic [IDXW-1:0]     w_hold_idx;

  assign cmd_ready = ~r_hold_valid;
  assign w_accept  = valid_in & cmd_ready;

  // Decode incoming command legality and the held command's issue condition.
  always_comb begin
    w_cmd_legal = 1'b0;
    w_is_rw     = 1'b0;
    w_issue     = 1'b0;
    w_hold_idx  = IDXW'(int'(r_hold_bg) * BANKS_PER_GROUP + int'(r_hold_bank));
    if (cmd_in == CMD_ACT || cmd_in == CMD_PRE ||
        cmd_in == CMD_READ || cmd_in == CMD_WRITE) begin
      w_cmd_legal = 1'b1;
    end
    if (r_hold_cmd == CMD_READ || r_hold_cmd == CMD_WRITE) begin
      w_is_rw = 1'b1;
    end
    // Bank timer always gates; the burst timer gates only column commands.
    if (r_hold_valid && (r_bank_timer[w_hold_idx] == '0) &&
        (!w_is_rw || (r_burst_timer == '0))) begin
      w_issue = 1'b1;
    end
  end

  // One-entry hold register: NOP and unknown codes are accepted but dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold_valid <= 1'b0;
      r_hold_cmd   <= CMD_NOP;
      r_hold_bg    <= '0;
      r_hold_bank  <= '0;
      r_hold_row   <= '0;
      r_hold_col   <= '0;
      r_hold_wdata <= '0;
    end else begin
      if (w_issue) begin
        r_hold_valid <= 1'b0;
      end
      if (w_accept && w_cmd_legal) begin
        r_hold_valid <= 1'b1;
        r_hold_cmd   <= cmd_in;
        r_hold_bg    <= bank_group_in;
        r_hold_bank  <= bank_in;
        r_hold_row   <= row_in;
        r_hold_col   <= col_in;
        r_hold_wdata <= val_in;
      end
    end
  end

  // Per-bank timers load on ACT/PRE issue and otherwise count down to 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NB; i++) begin
        r_bank_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_issue && (w_hold_idx == IDXW'(i)) && (r_hold_cmd == CMD_ACT)) begin
          r_bank_timer[i] <= ACT_LOAD;
        end else if (w_issue && (w_hold_idx == IDXW'(i)) && (r_hold_cmd == CMD_PRE)) begin
          r_bank_timer[i] <= PRE_LOAD;
        end else if (r_bank_timer[i] != '0) begin
          r_bank_timer[i] <= r_bank_timer[i] - 1'b1;
        end
      end
    end
  end

  // Shared burst timer spaces READ/WRITE issues across all banks.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_burst_timer <= '0;
    end else if (w_issue && w_is_rw) begin
      r_burst_timer <= BURST_LOAD;
    end else if (r_burst_timer != '0) begin
      r_burst_timer <= r_burst_timer - 1'b1;
    end
  end

  // Registered DRAM outputs: strobe for one cycle, fields hold between issues.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dram_valid_out <= 1'b0;
      dram_cmd_out   <= CMD_NOP;
      dram_bg_out    <= '0;
      dram_bank_out  <= '0;
      dram_row_out   <= '0;
      dram_col_out   <= '0;
      dram_wdata_out <= '0;
    end else begin
      dram_valid_out <= w_issue;
      if (w_issue) begin
        dram_cmd_out   <= r_hold_cmd;
        dram_bg_out    <= r_hold_bg;
        dram_bank_out  <= r_hold_bank;
        dram_row_out   <= r_hold_row;
        dram_col_out   <= r_hold_col;
        dram_wdata_out <= r_hold_wdata;
      end
    end
  end

`ifdef DRAM_CMD_ISSUER_PROTOCOL_CHECK_EN
  logic                r_bank_open [NB];
  logic [ROW_BITS-1:0] r_open_row  [NB];
  logic                r_err;
  logic                w_violation;

  // Flag ACT to an open bank and column access to a closed or different row.
  always_comb begin
    w_violation = 1'b0;
    if (w_issue) begin
      if (r_hold_cmd == CMD_ACT && r_bank_open[w_hold_idx]) begin
        w_violation = 1'b1;
      end
      if (w_is_rw && (!r_bank_open[w_hold_idx] ||
                      (r_open_row[w_hold_idx] != r_hold_row))) begin
        w_violation = 1'b1;
      end
    end
  end

  // Track open/closed state per bank as commands issue; error is sticky.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        r_bank_open[i] <= 1'b0;
        r_open_row[i]  <= '0;
      end
    end else begin
      if (w_violation) begin
        r_err <= 1'b1;
      end
      if (w_issue && r_hold_cmd == CMD_ACT) begin
        r_bank_open[w_hold_idx] <= 1'b1;
        r_open_row[w_hold_idx]  <= r_hold_row;
      end else if (w_issue && r_hold_cmd == CMD_PRE) begin
        r_bank_open[w_hold_idx] <= 1'b0;
      end
    end
  end

  assign err_out = r_err;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Testbench for dram_cmd_issuer: scoreboard with a cycle-level reference
// model based on earliest-legal-issue edge numbers per bank and for bursts.
module tb_dram_cmd_issuer;

  localparam int ACT_LAT   = 8;
  localparam int PRE_LAT   = 5;
  localparam int BURST     = 4;
`ifdef DRAM_CMD_ISSUER_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [2:0]  cmd_in = '0;
  logic        valid_in = 1'b0;
  logic [2:0]  bank_group_in = '0;
  logic [2:0]  bank_in = '0;
  logic [7:0]  row_in = '0;
  logic [3:0]  col_in = '0;
  logic [63:0] val_in = '0;
  logic        cmd_ready;
  logic [2:0]  dram_cmd_out;
  logic        dram_valid_out;
  logic [2:0]  dram_bg_out;
  logic [2:0]  dram_bank_out;
  logic [7:0]  dram_row_out;
  logic [3:0]  dram_col_out;
  logic [63:0] dram_wdata_out;
  logic        err_out;

  dram_cmd_issuer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cmd_in         (cmd_in),
    .valid_in       (valid_in),
    .bank_group_in  (bank_group_in),
    .bank_in        (bank_in),
    .row_in         (row_in),
    .col_in         (col_in),
    .val_in         (val_in),
    .cmd_ready      (cmd_ready),
    .dram_cmd_out   (dram_cmd_out),
    .dram_valid_out (dram_valid_out),
    .dram_bg_out    (dram_bg_out),
    .dram_bank_out  (dram_bank_out),
    .dram_row_out   (dram_row_out),
    .dram_col_out   (dram_col_out),
    .dram_wdata_out (dram_wdata_out),
    .err_out        (err_out)
  );

  always #5 clk_in = ~clk_in;

  int edge_cnt = 0;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  bg;
    logic [2:0]  bank;
    logic [7:0]  row;
    logic [3:0]  col;
    logic [63:0] wdata;
    int          edge_no;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;

  // Reference model: edge number at which each bank / the burst slot frees up.
  int          bank_free [64];
  int          burst_free;
  bit          m_open [64];
  logic [7:0]  m_row [64];
  bit          m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      bank_free[i] = 0;
      m_open[i] = 1'b0;
      m_row[i] = '0;
    end
    burst_free = 0;
    m_err = 1'b0;
  endtask

  task automatic model_accept(input logic [2:0] c, input logic [2:0] bg, input logic [2:0] bk,
                              input logic [7:0] row, input logic [3:0] col, input logic [63:0] wd);
    exp_t e;
    int   n, idx, t;
    bit   rw;
    if (!(c == 3'd1 || c == 3'd2 || c == 3'd3 || c == 3'd4)) return;
    n   = edge_cnt + 1;
    idx = int'(bg) * 8 + int'(bk);
    rw  = (c == 3'd3 || c == 3'd4);
    t   = n + 1;
    if (bank_free[idx] > t) t = bank_free[idx];
    if (rw && burst_free > t) t = burst_free;
    if (c == 3'd1) begin
      if (m_open[idx]) m_err = 1'b1;
      m_open[idx] = 1'b1;
      m_row[idx] = row;
      bank_free[idx] = t + ACT_LAT;
    end else if (c == 3'd2) begin
      m_open[idx] = 1'b0;
      bank_free[idx] = t + PRE_LAT;
    end else begin
      if (!m_open[idx] || m_row[idx] != row) m_err = 1'b1;
      burst_free = t + BURST;
    end
    if (!CHK) m_err = 1'b0;
    e.cmd = c; e.bg = bg; e.bank = bk; e.row = row; e.col = col; e.wdata = wd;
    e.edge_no = t; e.err = m_err;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge one cycle after the accept edge.
  task automatic send(input logic [2:0] c, input logic [2:0] bg, input logic [2:0] bk,
                      input logic [7:0] row, input logic [3:0] col, input logic [63:0] wd);
    int guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk_in);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready stuck at %0b, wanted 1", cmd_ready);
      return;
    end
    cmd_in = c; bank_group_in = bg; bank_in = bk; row_in = row; col_in = col; val_in = wd;
    valid_in = 1'b1;
    model_accept(c, bg, bk, row, col, wd);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk_in);
      guard++;
    end
    chk("drain_pending", sb.size(), 0);
    @(negedge clk_in);
    chk("err_level", err_out, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    sb.delete();
    model_reset();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_valid", dram_valid_out, 1'b0);
    chk("rst_cmd", dram_cmd_out, 3'b000);
    chk("rst_err", err_out, 1'b0);
  endtask

  // Monitor: every issue strobe must match the oldest expected command.
  always @(negedge clk_in) begin
    if (!rst_in && dram_valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: cmd %0d with empty scoreboard, wanted no issue", dram_cmd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_fields",
            {dram_cmd_out, dram_bg_out, dram_bank_out, dram_row_out, dram_col_out, dram_wdata_out},
            {e.cmd, e.bg, e.bank, e.row, e.col, e.wdata});
        chk("issue_edge", edge_cnt, e.edge_no);
        chk("issue_err", err_out, e.err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time %0t, wanted finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // ACT then READ on bg3/b2: READ waits out the activation latency.
    send(3'd1, 3'd3, 3'd2, 8'h55, 4'h0, 64'h1111);
    send(3'd3, 3'd3, 3'd2, 8'h55, 4'hA, 64'h2222);
    drain();

    // PRE then ACT on bg2/b1: ACT waits out the precharge latency.
    send(3'd2, 3'd2, 3'd1, 8'h00, 4'h0, 64'h0);
    send(3'd1, 3'd2, 3'd1, 8'hF0, 4'h0, 64'h3);
    drain();

    // Open two banks, then READ and WRITE back to back: burst spacing.
    send(3'd1, 3'd0, 3'd0, 8'h12, 4'h0, 64'h0);
    send(3'd1, 3'd1, 3'd1, 8'h34, 4'h0, 64'h0);
    drain();
    send(3'd3, 3'd0, 3'd0, 8'h12, 4'h3, 64'h0);
    send(3'd4, 3'd1, 3'd1, 8'h34, 4'h5, 64'hA5A5A5A5A5A5A5A5);
    drain();

    // Independent banks: second ACT is not delayed by the first.
    do_reset();
    send(3'd1, 3'd0, 3'd0, 8'h01, 4'h0, 64'h0);
    send(3'd1, 3'd0, 3'd1, 8'h02, 4'h0, 64'h0);
    drain();

    // Illegal codes and NOP are dropped without issuing.
    send(3'd0, 3'd5, 3'd5, 8'h77, 4'h7, 64'h77);
    send(3'd7, 3'd5, 3'd5, 8'h77, 4'h7, 64'h77);
    drain();

    // READ to a closed bank still issues; error flag depends on the build.
    send(3'd3, 3'd4, 3'd4, 8'h09, 4'h1, 64'hDEAD);
    drain();
    repeat (3) @(negedge clk_in);
    chk("err_sticky", err_out, m_err);

    // Reset while a command is held: it must be discarded.
    do_reset();
    send(3'd1, 3'd6, 3'd6, 8'h40, 4'h0, 64'h0);
    send(3'd3, 3'd6, 3'd6, 8'h40, 4'h2, 64'h0);
    do_reset();
    repeat (12) @(negedge clk_in);

    // Randomized traffic on a small bank set to force timing conflicts.
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  c, bg, bk;
      logic [7:0]  row;
      logic [3:0]  col;
      logic [63:0] wd;
      c   = 3'($urandom_range(0, 7));
      bg  = 3'($urandom_range(0, 1));
      bk  = 3'($urandom_range(0, 1));
      row = 8'($urandom_range(0, 3));
      col = 4'($urandom_range(0, 15));
      wd  = {$urandom, $urandom};
      send(c, bg, bk, row, col, wd);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
    drain();

    do_reset();
    repeat (2) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
